// File: rtl/dff_pipe_rs_pkg.sv
// Shared types for the dff_pipe_rs register pipeline.
// A stage either loads a new word, keeps a stalled word, or drains to empty.
package dff_pipe_rs_pkg;

    typedef struct packed {
        logic load;   // take the upstream word this edge
        logic keep;   // current word is valid and cannot move on
    } stage_ctrl_t;

    function automatic logic stage_vld_next(input stage_ctrl_t ctrl);
        return ctrl.load | ctrl.keep;
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One register stage: clock-enabled data register plus its valid bit.
// Rst is asynchronous, Clr a synchronous flush; both restore RST_VAL.
module dff_pipe_stage
    import dff_pipe_rs_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Clr,
    input  stage_ctrl_t      ctrl,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             vld
);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            vld <= 1'b0;
            q   <= RST_VAL;
        end else if (Clr) begin
            vld <= 1'b0;
            q   <= RST_VAL;
        end else begin
            vld <= stage_vld_next(ctrl);
            if (ctrl.load) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/dff_pipe_rs.sv
// DEPTH-stage registered delay line with valid/ready handshake and bubble collapse.
// The ready chain is combinational from out_ready; data and valid outputs are registered.
module dff_pipe_rs
    import dff_pipe_rs_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [DEPTH-1:0] rdy;      // stage i can accept a word this edge
    logic [DEPTH-1:0] rdy_dn;   // whatever lies downstream of stage i can take its word

    // Walk from the output side: a stage is ready if it is empty or its successor is.
    always_comb begin
        logic chain;
        rdy    = '0;
        rdy_dn = '0;
        chain  = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy_dn[i] = chain;
            chain     = !vld[i] | chain;
            rdy[i]    = chain;
        end
    end

    assign in_ready = rdy[0] & !Clr;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            stage_ctrl_t      ctrl;
            logic [WIDTH-1:0] d_in;

            if (gi == 0) begin : g_head
                assign ctrl.load = in_valid & in_ready;
                assign d_in      = in_data;
            end else begin : g_body
                assign ctrl.load = vld[gi-1] & rdy[gi];
                assign d_in      = dat[gi-1];
            end

            assign ctrl.keep = vld[gi] & !rdy_dn[gi];

            dff_pipe_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .Clk  (Clk),
                .Rst  (Rst),
                .Clr  (Clr),
                .ctrl (ctrl),
                .d    (d_in),
                .q    (dat[gi]),
                .vld  (vld[gi])
            );
        end
    endgenerate

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(vld[i]);
        end
    end

endmodule

// File: tb/tb_dff_pipe_rs.sv
// Bench for dff_pipe_rs: directed vector table, hand-written corner sequences and
// random traffic against a queue-of-words reference model (two RST_VAL variants).
module tb_dff_pipe_rs;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam int         OCC_W = $clog2(DEPTH + 1);
    localparam logic [7:0] RV0   = 8'h00;
    localparam logic [7:0] RV1   = 8'h5A;

    logic             Clk, Rst, Clr, in_valid, out_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_ready0, in_ready1, out_valid0, out_valid1;
    logic [WIDTH-1:0] out_data0, out_data1;
    logic [OCC_W-1:0] occ0, occ1;

    int checks = 0;
    int errors = 0;

    dff_pipe_rs #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RV0)) dut0 (
        .Clk(Clk), .Rst(Rst), .Clr(Clr),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .occupancy(occ0)
    );

    dff_pipe_rs #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RV1)) dut1 (
        .Clk(Clk), .Rst(Rst), .Clr(Clr),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: words in acceptance order with their stage position.
    // A word moves on when any slot downstream of it is free or out_ready is high.
    typedef struct {
        logic [7:0] d;
        int         pos;
    } word_t;

    word_t      q[$];
    logic [7:0] last_out;
    bit         last_set;

    function automatic bit m_out_valid();
        return (q.size() > 0) && (q[0].pos == DEPTH - 1);
    endfunction

    function automatic bit m_in_ready();
        return !Clr && ((q.size() < DEPTH) || out_ready);
    endfunction

    function automatic logic [7:0] m_out_data(input logic [7:0] rv);
        if (m_out_valid()) return q[0].d;
        if (last_set) return last_out;
        return rv;
    endfunction

    task automatic model_reset();
        q.delete();
        last_set = 0;
    endtask

    task automatic model_edge();
        word_t nq[$];
        bit    acc;
        if (Clr) begin
            model_reset();
            return;
        end
        acc = in_valid && m_in_ready();
        for (int k = 0; k < q.size(); k++) begin
            word_t w;
            w = q[k];
            if ((DEPTH - 1 - w.pos > k) || out_ready) w.pos++;
            if (w.pos < DEPTH) nq.push_back(w);
            else $display("xfer out data=%02h t=%0t", w.d, $time);
        end
        if (acc) nq.push_back('{d: in_data, pos: 0});
        q = nq;
        foreach (q[k]) begin
            if (q[k].pos == DEPTH - 1) begin
                last_out = q[k].d;
                last_set = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_ir0"},  32'(in_ready0),  32'(m_in_ready()));
        chk({tag, "_ir1"},  32'(in_ready1),  32'(m_in_ready()));
        chk({tag, "_ov0"},  32'(out_valid0), 32'(m_out_valid()));
        chk({tag, "_ov1"},  32'(out_valid1), 32'(m_out_valid()));
        chk({tag, "_occ0"}, 32'(occ0),       32'(q.size()));
        chk({tag, "_occ1"}, 32'(occ1),       32'(q.size()));
        chk({tag, "_od0"},  32'(out_data0),  32'(m_out_data(RV0)));
        chk({tag, "_od1"},  32'(out_data1),  32'(m_out_data(RV1)));
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic c);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        Clr       = c;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       ir;
        logic       ov;
        logic [7:0] od;
        int         occ;
    } vec_t;

    vec_t tbl[18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ordy_pct;

        // Stream 11..44 unstalled, then 5 words into a stalled pipe and drain.
        tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 0};
        tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 1};
        tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 2};
        tbl[3]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h11, 3};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 1};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h44, 0};
        tbl[8]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h44, 0};
        tbl[9]  = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 8'h44, 1};
        tbl[10] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 8'h44, 2};
        tbl[11] = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 8'h55, 3};
        tbl[12] = '{1'b1, 8'h88, 1'b1, 1'b1, 1'b1, 8'h55, 3};
        tbl[13] = '{1'b1, 8'h99, 1'b1, 1'b1, 1'b1, 8'h66, 3};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 3};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h88, 2};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h99, 1};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h99, 0};

        Rst = 1'b0; Clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        last_out = '0; last_set = 0;

        // Reset pulse in the first clock-low phase, checked before any edge.
        #2 Rst = 1'b1;
        #1;
        model_reset();
        chk("por_ov0",  32'(out_valid0), 32'd0);
        chk("por_od0",  32'(out_data0),  32'h00);
        chk("por_od1",  32'(out_data1),  32'h5A);
        chk("por_occ0", 32'(occ0),       32'd0);
        chk("por_ir0",  32'(in_ready0),  32'd1);
        #1 Rst = 1'b0;
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, 1'b0);
            chk($sformatf("row%0d_ir", i),  32'(in_ready0),  32'(tbl[i].ir));
            chk($sformatf("row%0d_ov", i),  32'(out_valid0), 32'(tbl[i].ov));
            chk($sformatf("row%0d_od", i),  32'(out_data0),  32'(tbl[i].od));
            chk($sformatf("row%0d_occ", i), 32'(occ0),       32'(tbl[i].occ));
            check_model($sformatf("row%0d", i));
            tick();
        end

        // Bubble: A1, idle, B2 under stall must pack towards the output.
        drive(1'b1, 8'hA1, 1'b0, 1'b0); check_model("bub0"); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0); check_model("bub1"); tick();
        drive(1'b1, 8'hB2, 1'b0, 1'b0); check_model("bub2"); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("bub_occ", 32'(occ0),       32'd2);
        chk("bub_ov",  32'(out_valid0), 32'd1);
        chk("bub_od",  32'(out_data0),  32'hA1);
        check_model("bub3");
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pack_occ", 32'(occ0),      32'd2);
        chk("pack_ir",  32'(in_ready0), 32'd1);
        check_model("pack");

        // Flush with two words held and a word offered at the input.
        drive(1'b1, 8'hC3, 1'b1, 1'b1);
        chk("clr_ir",  32'(in_ready0),  32'd0);
        chk("clr_ov",  32'(out_valid0), 32'd1);
        chk("clr_od",  32'(out_data0),  32'hA1);
        check_model("clr");
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("clr_occ", 32'(occ0),       32'd0);
        chk("clr_ov2", 32'(out_valid0), 32'd0);
        chk("clr_od0", 32'(out_data0),  32'h00);
        chk("clr_od1", 32'(out_data1),  32'h5A);
        for (int k = 0; k < 4; k++) begin
            check_model("postclr");
            tick();
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Asynchronous reset with a full pipe.
        drive(1'b1, 8'hD1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hD2, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hD3, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("full_occ", 32'(occ0), 32'd3);
        check_model("full");
        Rst = 1'b1;
        #1;
        model_reset();
        chk("arst_ov1", 32'(out_valid1), 32'd0);
        chk("arst_od1", 32'(out_data1),  32'h5A);
        chk("arst_od0", 32'(out_data0),  32'h00);
        chk("arst_occ", 32'(occ1),       32'd0);
        chk("arst_ir",  32'(in_ready1),  32'd1);
        #1 Rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk("arst_stale", 32'(out_valid1), 32'd0);
            check_model("postrst");
            tick();
        end

        // Random traffic with varying back-pressure, flushes and resets.
        ordy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) ordy_pct = $urandom_range(10, 95);
            if ($urandom_range(0, 299) == 0) begin
                Rst = 1'b1;
                #1;
                model_reset();
                check_model("rnd_rst");
                Rst = 1'b0;
            end
            drive($urandom_range(0, 99) < 70, 8'($urandom),
                  $urandom_range(0, 99) < ordy_pct, $urandom_range(0, 39) == 0);
            check_model("rnd");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
